// File: rtl/oq_regs_pkg.sv
// Shared types and defaults for the output-queue register RMW controller.
//   - RegWidthDefault / NumQueuesDefault / AddrWidthDefault: default geometry
//   - op_e   : operation carried through the RMW pipeline
//   - state_e: controller top-level state (RAM clear vs. normal traffic)
package oq_regs_pkg;

  localparam int unsigned RegWidthDefault  = 32;
  localparam int unsigned NumQueuesDefault = 8;
  localparam int unsigned AddrWidthDefault = 3;

  typedef enum logic [1:0] {
    OpUpdAdd = 2'd0,
    OpUpdSub = 2'd1,
    OpHostRd = 2'd2,
    OpHostWr = 2'd3
  } op_e;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Host operations are the ones that must produce host_ack.
  function automatic logic op_is_host(input op_e op);
    return (op == OpHostRd) || (op == OpHostWr);
  endfunction

endpackage

// File: rtl/oq_regs_sat_addsub.sv
// Combinational saturating add/subtract for the per-queue counters.
//   a_i     : current counter value
//   b_i     : operand
//   sub_i   : 1 = a_i - b_i (clamp at 0), 0 = a_i + b_i (clamp at all-ones)
//   res_o   : result
//   uflow_o : high when a subtract clamped to 0 (b_i > a_i)
module oq_regs_sat_addsub #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] res_o,
  output logic             uflow_o
);

  logic [Width:0] sum;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    res_o   = '0;
    uflow_o = 1'b0;
    if (sub_i) begin
      if (b_i > a_i) begin
        uflow_o = 1'b1;
      end else begin
        res_o = a_i - b_i;
      end
    end else begin
      // Carry out means the sum wrapped; pin to all-ones instead.
      res_o = sum[Width] ? '1 : sum[Width-1:0];
    end
  end

endmodule

// File: rtl/oq_regs_rmw_ctrl.sv
// Read-modify-write controller for the per-queue register RAM.
// Port A of the RAM is read-only (ram_rd_*), port B is write-only (ram_wr_*).
// Pipeline: S0 issue (host has priority) -> S1 compute (with forwarding) ->
// S2 commit (registered RAM write, host_ack, underflow_err).
// After reset every RAM entry is cleared before traffic is accepted.
//   clk_i/reset_i        : clock, asynchronous active-high reset
//   upd_*                : counter update stream from the output-queue datapath
//   host_*               : host register access, host_req held until host_ack
//   ram_rd_addr_o        : RAM port A address (read data on ram_rd_data_i next cycle)
//   ram_wr_*             : RAM port B write
//   underflow_err_o      : one-cycle pulse when a subtract clamps to 0
module oq_regs_rmw_ctrl
  import oq_regs_pkg::*;
#(
  parameter int unsigned REG_WIDTH         = RegWidthDefault,
  parameter int unsigned NUM_OUTPUT_QUEUES = NumQueuesDefault,
  parameter int unsigned ADDR_WIDTH        = AddrWidthDefault
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [ADDR_WIDTH-1:0] upd_queue_i,
  input  logic                  upd_inc_i,
  input  logic [REG_WIDTH-1:0]  upd_amount_i,
  input  logic                  host_req_i,
  input  logic                  host_rd_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [REG_WIDTH-1:0]  host_wr_data_i,
  output logic                  host_ack_o,
  output logic [REG_WIDTH-1:0]  host_rd_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [REG_WIDTH-1:0]  ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic                  ram_wr_en_o,
  output logic [REG_WIDTH-1:0]  ram_wr_data_o,
  output logic                  underflow_err_o
);

  localparam logic [ADDR_WIDTH:0] NumQ = (ADDR_WIDTH + 1)'(NUM_OUTPUT_QUEUES);

  // Control state
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   init_ptr_q, init_ptr_d;
  logic                  host_busy_q, host_busy_d;

  // S1 (compute) registers
  logic                  s1_valid_q, s1_valid_d;
  op_e                   s1_op_q, s1_op_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [REG_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic                  s1_in_range_q, s1_in_range_d;

  // S2 (commit) registers, driven straight onto the outputs
  logic                  ram_wr_en_q, ram_wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [REG_WIDTH-1:0]  ram_wr_data_q, ram_wr_data_d;
  logic                  host_ack_q, host_ack_d;
  logic [REG_WIDTH-1:0]  host_rd_data_q, host_rd_data_d;
  logic                  underflow_err_q, underflow_err_d;

  // One-cycle-delayed copy of the previous port B write
  logic                  fwd_valid_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  logic [REG_WIDTH-1:0]  fwd_data_q;

  logic                  run;
  logic                  host_grant;
  logic                  upd_fire;
  logic [REG_WIDTH-1:0]  old_val;
  logic [REG_WIDTH-1:0]  sat_res;
  logic                  sat_uflow;
  logic [REG_WIDTH-1:0]  new_val;

  // ---------------------------------------------------------------------------
  // S0: issue
  // ---------------------------------------------------------------------------
  assign run         = (state_q == StRun);
  assign host_grant  = run && host_req_i && !host_busy_q;
  assign upd_ready_o = run && !(host_req_i && !host_busy_q);
  assign upd_fire    = upd_valid_i && upd_ready_o;

  always_comb begin
    ram_rd_addr_o = host_grant ? host_addr_i : upd_queue_i;
    s1_valid_d    = host_grant || upd_fire;
    s1_addr_d     = ram_rd_addr_o;
    s1_in_range_d = ({1'b0, ram_rd_addr_o} < NumQ);
    if (host_grant) begin
      s1_op_d   = host_rd_i ? OpHostRd : OpHostWr;
      s1_data_d = host_wr_data_i;
    end else begin
      s1_op_d   = upd_inc_i ? OpUpdAdd : OpUpdSub;
      s1_data_d = upd_amount_i;
    end
  end

  // A granted host access stays outstanding until its ack has been driven.
  always_comb begin
    host_busy_d = host_busy_q;
    if (host_grant) begin
      host_busy_d = 1'b1;
    end else if (host_ack_q) begin
      host_busy_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: compute
  // ---------------------------------------------------------------------------
  // The RAM read was issued before the two most recent writes landed, so the
  // newest matching in-flight write wins over the RAM data.
  always_comb begin
    if (ram_wr_en_q && (ram_wr_addr_q == s1_addr_q)) begin
      old_val = ram_wr_data_q;
    end else if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
      old_val = fwd_data_q;
    end else begin
      old_val = ram_rd_data_i;
    end
  end

  oq_regs_sat_addsub #(
    .Width (REG_WIDTH)
  ) u_sat_addsub (
    .a_i     (old_val),
    .b_i     (s1_data_q),
    .sub_i   (s1_op_q == OpUpdSub),
    .res_o   (sat_res),
    .uflow_o (sat_uflow)
  );

  assign new_val = (s1_op_q == OpHostWr) ? s1_data_q : sat_res;

  // ---------------------------------------------------------------------------
  // S2 commit and RAM clear sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    init_ptr_d      = init_ptr_q;
    ram_wr_en_d     = 1'b0;
    ram_wr_addr_d   = ram_wr_addr_q;
    ram_wr_data_d   = ram_wr_data_q;
    host_ack_d      = s1_valid_q && op_is_host(s1_op_q);
    host_rd_data_d  = host_rd_data_q;
    underflow_err_d = s1_valid_q && s1_in_range_q && (s1_op_q == OpUpdSub) && sat_uflow;

    if (s1_valid_q && s1_in_range_q && (s1_op_q != OpHostRd)) begin
      ram_wr_en_d   = 1'b1;
      ram_wr_addr_d = s1_addr_q;
      ram_wr_data_d = new_val;
    end
    if (s1_valid_q && (s1_op_q == OpHostRd)) begin
      host_rd_data_d = s1_in_range_q ? old_val : '0;
    end

    // Nothing is issued while clearing, so S1 is idle and the clear owns port B.
    if (state_q == StInit) begin
      if (init_ptr_q == NumQ) begin
        state_d = StRun;
      end else begin
        ram_wr_en_d   = 1'b1;
        ram_wr_addr_d = init_ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data_d = '0;
        init_ptr_d    = init_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StInit;
      init_ptr_q      <= '0;
      host_busy_q     <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_op_q         <= OpUpdAdd;
      s1_addr_q       <= '0;
      s1_data_q       <= '0;
      s1_in_range_q   <= 1'b0;
      ram_wr_en_q     <= 1'b0;
      ram_wr_addr_q   <= '0;
      ram_wr_data_q   <= '0;
      host_ack_q      <= 1'b0;
      host_rd_data_q  <= '0;
      underflow_err_q <= 1'b0;
      fwd_valid_q     <= 1'b0;
      fwd_addr_q      <= '0;
      fwd_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      init_ptr_q      <= init_ptr_d;
      host_busy_q     <= host_busy_d;
      s1_valid_q      <= s1_valid_d;
      s1_op_q         <= s1_op_d;
      s1_addr_q       <= s1_addr_d;
      s1_data_q       <= s1_data_d;
      s1_in_range_q   <= s1_in_range_d;
      ram_wr_en_q     <= ram_wr_en_d;
      ram_wr_addr_q   <= ram_wr_addr_d;
      ram_wr_data_q   <= ram_wr_data_d;
      host_ack_q      <= host_ack_d;
      host_rd_data_q  <= host_rd_data_d;
      underflow_err_q <= underflow_err_d;
      fwd_valid_q     <= ram_wr_en_q;
      fwd_addr_q      <= ram_wr_addr_q;
      fwd_data_q      <= ram_wr_data_q;
    end
  end

  assign ram_wr_en_o     = ram_wr_en_q;
  assign ram_wr_addr_o   = ram_wr_addr_q;
  assign ram_wr_data_o   = ram_wr_data_q;
  assign host_ack_o      = host_ack_q;
  assign host_rd_data_o  = host_rd_data_q;
  assign underflow_err_o = underflow_err_q;

endmodule

// File: tb/tb_oq_regs_rmw_ctrl.sv
// Directed bench for oq_regs_rmw_ctrl with a read-before-write RAM model.
module tb_oq_regs_rmw_ctrl;

  localparam logic [1:0] KAdd = 2'd0;
  localparam logic [1:0] KSub = 2'd1;
  localparam logic [1:0] KRd  = 2'd2;
  localparam logic [1:0] KWr  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_queue;
  logic        upd_inc;
  logic [31:0] upd_amount;
  logic        host_req;
  logic        host_rd;
  logic [2:0]  host_addr;
  logic [31:0] host_wr_data;
  logic        host_ack;
  logic [31:0] host_rd_data;
  logic [2:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [2:0]  ram_wr_addr;
  logic        ram_wr_en;
  logic [31:0] ram_wr_data;
  logic        underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  // Power-up garbage so the clear is observable.
  logic [31:0] mem [8] = '{default: 32'hA5A5_A5A5};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  oq_regs_rmw_ctrl #(
    .REG_WIDTH         (32),
    .NUM_OUTPUT_QUEUES (8),
    .ADDR_WIDTH        (3)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .upd_valid_i     (upd_valid),
    .upd_ready_o     (upd_ready),
    .upd_queue_i     (upd_queue),
    .upd_inc_i       (upd_inc),
    .upd_amount_i    (upd_amount),
    .host_req_i      (host_req),
    .host_rd_i       (host_rd),
    .host_addr_i     (host_addr),
    .host_wr_data_i  (host_wr_data),
    .host_ack_o      (host_ack),
    .host_rd_data_o  (host_rd_data),
    .ram_rd_addr_o   (ram_rd_addr),
    .ram_rd_data_i   (ram_rd_data),
    .ram_wr_addr_o   (ram_wr_addr),
    .ram_wr_en_o     (ram_wr_en),
    .ram_wr_data_o   (ram_wr_data),
    .underflow_err_o (underflow_err)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  q;
    logic [31:0] val;
    logic        we;
    logic [31:0] exp;  // written value, or read data for host reads
    logic        uf;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    upd_valid    = 1'b0;
    upd_queue    = '0;
    upd_inc      = 1'b0;
    upd_amount   = '0;
    host_req     = 1'b0;
    host_rd      = 1'b0;
    host_addr    = '0;
    host_wr_data = '0;
  endtask

  task automatic drive_op(input logic [1:0] k, input logic [2:0] q, input logic [31:0] v);
    if (k == KRd || k == KWr) begin
      host_req     = 1'b1;
      host_rd      = (k == KRd);
      host_addr    = q;
      host_wr_data = v;
    end else begin
      upd_valid  = 1'b1;
      upd_inc    = (k == KAdd);
      upd_queue  = q;
      upd_amount = v;
    end
  endtask

  // Call at the start of the cycle in which reset has just been released.
  task automatic init_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, " init wr_en"}, {31'b0, ram_wr_en}, 32'd1);
      chk({tag, " init wr_addr"}, {29'b0, ram_wr_addr}, 32'(i));
      chk({tag, " init wr_data"}, ram_wr_data, 32'd0);
      chk({tag, " init upd_ready"}, {31'b0, upd_ready}, 32'd0);
      chk({tag, " init host_ack"}, {31'b0, host_ack}, 32'd0);
    end
    tick();
    chk({tag, " run upd_ready"}, {31'b0, upd_ready}, 32'd1);
    chk({tag, " run wr_en"}, {31'b0, ram_wr_en}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " upd_ready"}, {31'b0, upd_ready}, 32'd0);
    chk({tag, " host_ack"}, {31'b0, host_ack}, 32'd0);
    chk({tag, " host_rd_data"}, host_rd_data, 32'd0);
    chk({tag, " wr_en"}, {31'b0, ram_wr_en}, 32'd0);
    chk({tag, " wr_addr"}, {29'b0, ram_wr_addr}, 32'd0);
    chk({tag, " wr_data"}, ram_wr_data, 32'd0);
    chk({tag, " underflow"}, {31'b0, underflow_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{KAdd, 3'd0, 32'd10,         1'b1, 32'd10,         1'b0};
    vecs[1]  = '{KSub, 3'd0, 32'd3,          1'b1, 32'd7,          1'b0};
    vecs[2]  = '{KWr,  3'd5, 32'h1234_5678,  1'b1, 32'h1234_5678,  1'b0};
    vecs[3]  = '{KRd,  3'd5, 32'd0,          1'b0, 32'h1234_5678,  1'b0};
    vecs[4]  = '{KSub, 3'd3, 32'd1,          1'b1, 32'd0,          1'b1};
    vecs[5]  = '{KAdd, 3'd7, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b0};
    vecs[6]  = '{KAdd, 3'd7, 32'd1,          1'b1, 32'hFFFF_FFFF,  1'b0};
    vecs[7]  = '{KSub, 3'd7, 32'hFFFF_FFFF,  1'b1, 32'd0,          1'b0};
    vecs[8]  = '{KRd,  3'd0, 32'd0,          1'b0, 32'd7,          1'b0};
    vecs[9]  = '{KRd,  3'd6, 32'd0,          1'b0, 32'd0,          1'b0};
    vecs[10] = '{KWr,  3'd1, 32'd2,          1'b1, 32'd2,          1'b0};
    vecs[11] = '{KSub, 3'd1, 32'd10,         1'b1, 32'd0,          1'b1};
    vecs[12] = '{KRd,  3'd1, 32'd0,          1'b0, 32'd0,          1'b0};

    idle();
    reset = 1'b1;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    init_check("por");

    // Isolated operations, one every three cycles.
    for (int i = 0; i < 13; i++) begin
      logic is_host;
      is_host = (vecs[i].kind == KRd) || (vecs[i].kind == KWr);
      drive_op(vecs[i].kind, vecs[i].q, vecs[i].val);
      #1;
      if (!is_host) chk($sformatf("v%0d upd_ready", i), {31'b0, upd_ready}, 32'd1);
      tick();
      upd_valid = 1'b0;
      tick();
      chk($sformatf("v%0d wr_en", i), {31'b0, ram_wr_en}, {31'b0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("v%0d wr_addr", i), {29'b0, ram_wr_addr}, {29'b0, vecs[i].q});
        chk($sformatf("v%0d wr_data", i), ram_wr_data, vecs[i].exp);
      end
      chk($sformatf("v%0d underflow", i), {31'b0, underflow_err}, {31'b0, vecs[i].uf});
      chk($sformatf("v%0d host_ack", i), {31'b0, host_ack}, {31'b0, is_host});
      if (vecs[i].kind == KRd) chk($sformatf("v%0d rd_data", i), host_rd_data, vecs[i].exp);
      host_req = 1'b0;
      tick();
      chk($sformatf("v%0d ack pulse", i), {31'b0, host_ack}, 32'd0);
      chk($sformatf("v%0d uf pulse", i), {31'b0, underflow_err}, 32'd0);
      chk($sformatf("v%0d wr_en idle", i), {31'b0, ram_wr_en}, 32'd0);
    end

    // Back-to-back same-queue updates; last one relies on the delayed forward.
    drive_op(KAdd, 3'd2, 32'd5);
    tick();
    drive_op(KAdd, 3'd2, 32'd7);
    tick();
    drive_op(KSub, 3'd2, 32'd3);
    chk("b2b wr0 addr", {29'b0, ram_wr_addr}, 32'd2);
    chk("b2b wr0 data", ram_wr_data, 32'd5);
    tick();
    drive_op(KAdd, 3'd1, 32'd1);
    chk("b2b wr1 data", ram_wr_data, 32'd12);
    tick();
    drive_op(KAdd, 3'd2, 32'd4);
    chk("b2b wr2 data", ram_wr_data, 32'd9);
    chk("b2b wr2 uf", {31'b0, underflow_err}, 32'd0);
    tick();
    idle();
    chk("b2b wr3 addr", {29'b0, ram_wr_addr}, 32'd1);
    chk("b2b wr3 data", ram_wr_data, 32'd1);
    tick();
    chk("b2b wr4 addr", {29'b0, ram_wr_addr}, 32'd2);
    chk("b2b wr4 data", ram_wr_data, 32'd13);
    tick();

    // Host write near max, then add that saturates.
    drive_op(KWr, 3'd4, 32'hFFFF_FFF0);
    tick();
    drive_op(KAdd, 3'd4, 32'h20);
    #1;
    chk("sat upd_ready", {31'b0, upd_ready}, 32'd1);
    tick();
    upd_valid = 1'b0;
    chk("sat hw ack", {31'b0, host_ack}, 32'd1);
    chk("sat hw data", ram_wr_data, 32'hFFFF_FFF0);
    host_req = 1'b0;
    tick();
    chk("sat add addr", {29'b0, ram_wr_addr}, 32'd4);
    chk("sat add data", ram_wr_data, 32'hFFFF_FFFF);
    chk("sat add uf", {31'b0, underflow_err}, 32'd0);
    tick();

    // Host read and update in the same cycle: update stalls one cycle.
    drive_op(KRd, 3'd2, 32'd0);
    drive_op(KAdd, 3'd2, 32'd1);
    #1;
    chk("coll ready t", {31'b0, upd_ready}, 32'd0);
    tick();
    chk("coll ready t+1", {31'b0, upd_ready}, 32'd1);
    tick();
    upd_valid = 1'b0;
    chk("coll ack", {31'b0, host_ack}, 32'd1);
    chk("coll rd_data", host_rd_data, 32'd13);
    chk("coll no wr", {31'b0, ram_wr_en}, 32'd0);
    host_req = 1'b0;
    tick();
    chk("coll upd wr_en", {31'b0, ram_wr_en}, 32'd1);
    chk("coll upd data", ram_wr_data, 32'd14);
    chk("coll ack gone", {31'b0, host_ack}, 32'd0);
    tick();

    // Reset with the pipeline full.
    drive_op(KRd, 3'd5, 32'd0);
    tick();
    drive_op(KAdd, 3'd3, 32'd1);
    tick();
    drive_op(KAdd, 3'd3, 32'd2);
    chk("full ack before reset", {31'b0, host_ack}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    idle();
    tick();
    tick();
    reset = 1'b0;
    init_check("rerst");

    // Queue 3 must read back cleared.
    drive_op(KRd, 3'd3, 32'd0);
    tick();
    tick();
    chk("post clear ack", {31'b0, host_ack}, 32'd1);
    chk("post clear rd", host_rd_data, 32'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oq_regs_rmw_ctrl.md
Name: oq_regs_rmw_ctrl

Overview:
- Read-modify-write controller that drives a two-port per-queue register RAM (sync read, sync write, read-before-write).
- Port A is used read-only. Port B is used write-only.
- Accepts per-queue counter updates (add/subtract, saturating) from the output-queue datapath, and host register reads/writes, one operation per cycle.
- On reset, clears every RAM entry before accepting traffic.
- Forwards in-flight results so back-to-back updates to the same queue are exact.

Parameters:
- REG_WIDTH, 32, counter/register width.
- NUM_OUTPUT_QUEUES, 8, number of RAM entries.
- ADDR_WIDTH, 3, log2(NUM_OUTPUT_QUEUES), width of queue/register index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when upd_valid&&upd_ready
- upd_queue  in  ADDR_WIDTH  target queue
- upd_inc  in  1  1=add, 0=subtract
- upd_amount  in  REG_WIDTH  operand
- host_req  in  1  host access request, held until host_ack
- host_rd  in  1  1=read, 0=write
- host_addr  in  ADDR_WIDTH  host register index
- host_wr_data  in  REG_WIDTH  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rd_data  out  REG_WIDTH  read data, valid with host_ack
- ram_rd_addr  out  ADDR_WIDTH  to RAM addr_a (we_a tied 0)
- ram_rd_data  in  REG_WIDTH  from RAM dout_a
- ram_wr_addr  out  ADDR_WIDTH  to RAM addr_b
- ram_wr_en  out  1  to RAM we_b
- ram_wr_data  out  REG_WIDTH  to RAM din_b
- underflow_err  out  1  one-cycle pulse when a subtract clamps to 0

Behaviour:
- Reset (async):
  - state=INIT, init_ptr=0.
  - All pipeline valids cleared; in-flight operations are discarded.
  - All registered outputs 0: upd_ready, host_ack, host_rd_data, ram_wr_en, ram_wr_addr, ram_wr_data, underflow_err.
- INIT:
  - Each cycle: ram_wr_en=1, ram_wr_addr=init_ptr, ram_wr_data=0, then init_ptr++.
  - After entry NUM_OUTPUT_QUEUES-1 is written, go to RUN.
  - upd_ready=0 and host_req is ignored throughout INIT.
  - Entering INIT mid-traffic (re-reset) restarts the clear from entry 0.
- RUN, stage S0 (issue):
  - Host has priority. Host is granted when host_req is high and host_busy=0.
  - A host grant sets host_busy; host_ack clears it.
  - upd_ready = RUN && !(host_req && !host_busy), combinational.
  - ram_rd_addr = address of the granted operation, combinational.
  - The operation is registered into S1.
- S1 (compute):
  - old value = forwarded data, or else ram_rd_data.
  - Forward sources, newest first:
    (a) the S2 write register currently on ram_wr_*;
    (b) a one-cycle-delayed copy of the previous write.
  - A forward applies when its valid is set and its address matches.
  - Add: old+amount, saturating at all-ones.
  - Subtract: if amount>old, result=0 and flag underflow; else old-amount.
  - Host write: result=host_wr_data.
  - Host read: no write; capture old value.
- S2 (commit), registered:
  - Update or host write: ram_wr_en=1 with its address and data.
  - Host op: host_ack=1; for a read, host_rd_data=value.
  - Underflow: underflow_err=1 for the one cycle.
- Latency: op accepted in cycle t → RAM write driven / host_ack in cycle t+2; write committed at end of t+2.
- Throughput: 1 op/cycle. Same-address streams at full rate must be exact via forwarding.
- Addresses ≥ NUM_OUTPUT_QUEUES:
  - Updates are dropped with no write.
  - Host reads return 0; host writes are dropped.
  - host_ack is still generated for host accesses.
- Simultaneous host_req and upd_valid: host wins; the update stalls exactly one cycle.
- Port B collision: never read the same address on port A in the same edge as a write on port B; forwarding covers it.

Decomposition:
- Package oq_regs_pkg: REG_WIDTH default, op-type encoding (OP_UPD_ADD, OP_UPD_SUB, OP_HOST_RD, OP_HOST_WR), state encoding (INIT, RUN).
- Sub-module oq_regs_sat_addsub: combinational saturating add/subtract with underflow flag, instantiated in S1.

Test Plan:
- Reset released; watch 8 cycles → ram_wr_en=1 with addresses 0..7 and data 0, upd_ready=0; upd_ready=1 on cycle 9.
- Add 5 to queue 2 at t, add 7 to queue 2 at t+1, subtract 3 from queue 2 at t+2 → ram_wr_data = 5, 12, 9 in cycles t+2, t+3, t+4.
- Host write 0xFFFFFFF0 to queue 4, then add 0x20 to queue 4 → written value 0xFFFFFFFF (saturated), no underflow_err.
- Queue 1 holds 2; subtract 10 → ram_wr_data=0 and underflow_err pulses one cycle.
- host_req (read, addr 2) and upd_valid both high in the same cycle → upd_ready=0 that cycle; host_ack 2 cycles later with the current value; the update is accepted the next cycle.
- Assert reset while the pipeline is full → all outputs 0 immediately (async); the INIT clear restarts from entry 0; no host_ack for in-flight ops.
